// File: rtl/btn_typematic.sv
// btn_typematic: N-channel push-button conditioner.
//   Each channel: 2-FF synchroniser -> debounce -> press/release edge pulses
//   -> typematic FSM (move on press, again after a delay, then periodically).
// Optional feature macro: BTN_TYPEMATIC_ACCEL_EN
//   When defined, the repeat period halves once ACCEL_AFTER repeat pulses
//   have been issued since the press.
// Ports:
//   clk_in       in   system clock
//   rst_n_in     in   synchronous reset, active low
//   btn_in       in   [NUM_CH] raw asynchronous buttons, 1 = pressed
//   mask_in      in   [NUM_CH] 1 = channel enabled for events
//   held_out     out  [NUM_CH] debounced level
//   press_out    out  [NUM_CH] 1-cycle pulse on debounced rising edge
//   release_out  out  [NUM_CH] 1-cycle pulse on debounced falling edge
//   move_out     out  [NUM_CH] 1-cycle typematic pulse
module btn_typematic #(
  parameter int unsigned NUM_CH             = 5,
  parameter int unsigned LOG_DEBOUNCE_COUNT = 20,
  parameter int unsigned LOG_DELAY_COUNT    = 25,
  parameter int unsigned LOG_REPEAT_COUNT   = 22,
  parameter int unsigned ACCEL_AFTER        = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [NUM_CH-1:0] btn_in,
  input  logic [NUM_CH-1:0] mask_in,
  output logic [NUM_CH-1:0] held_out,
  output logic [NUM_CH-1:0] press_out,
  output logic [NUM_CH-1:0] release_out,
  output logic [NUM_CH-1:0] move_out
);

  localparam int unsigned DW = LOG_DEBOUNCE_COUNT;
  localparam int unsigned TW = (LOG_DELAY_COUNT > LOG_REPEAT_COUNT) ?
                               LOG_DELAY_COUNT : LOG_REPEAT_COUNT;

  localparam logic [DW-1:0] DB_LAST     = '1;
  localparam logic [TW-1:0] DELAY_LAST  = TW'({LOG_DELAY_COUNT{1'b1}});
  localparam logic [TW-1:0] REPEAT_LAST = TW'({LOG_REPEAT_COUNT{1'b1}});

  // Elaboration-time sanity checks on the configuration.
  if (LOG_REPEAT_COUNT < 2) begin : g_bad_repeat
    $error("btn_typematic: LOG_REPEAT_COUNT must be >= 2");
  end
  if (ACCEL_AFTER < 1) begin : g_bad_accel
    $error("btn_typematic: ACCEL_AFTER must be >= 1");
  end

`ifdef BTN_TYPEMATIC_ACCEL_EN
  localparam int unsigned   AW        = $clog2(ACCEL_AFTER + 1);
  localparam logic [AW-1:0] ACCEL_LIM = AW'(ACCEL_AFTER);
  localparam logic [TW-1:0] FAST_LAST = TW'({(LOG_REPEAT_COUNT - 1){1'b1}});
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [NUM_CH-1:0] sync_a;
  logic [NUM_CH-1:0] sync_b;
  logic [NUM_CH-1:0] cand;
  logic [DW-1:0]     db_cnt [NUM_CH];
  logic [NUM_CH-1:0] held_nxt;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;

  state_t            state     [NUM_CH];
  state_t            state_nxt [NUM_CH];
  logic [TW-1:0]     timer     [NUM_CH];
  logic [TW-1:0]     timer_nxt [NUM_CH];
  logic [TW-1:0]     rep_last;
  logic [NUM_CH-1:0] press_nxt;
  logic [NUM_CH-1:0] release_nxt;
  logic [NUM_CH-1:0] move_nxt;

`ifdef BTN_TYPEMATIC_ACCEL_EN
  logic [AW-1:0]     rep_cnt     [NUM_CH];
  logic [AW-1:0]     rep_cnt_nxt [NUM_CH];
`endif

  // Synchroniser, debounce candidate/counter and debounced level.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync_a   <= '0;
      sync_b   <= '0;
      cand     <= '0;
      held_out <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_a   <= btn_in;
      sync_b   <= sync_a;
      held_out <= held_nxt;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sync_b[i] != cand[i]) begin
          cand[i]   <= sync_b[i];
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != DB_LAST) begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Level is accepted once the candidate has been stable for the full window.
  always_comb begin
    held_nxt = held_out;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (db_cnt[i] == DB_LAST) begin
        held_nxt[i] = cand[i];
      end
    end
  end

  // Edges are taken from the next level so pulses align with held_out.
  assign rise = held_nxt & ~held_out;
  assign fall = ~held_nxt & held_out;

  // Typematic FSM next-state and output decode, one instance per channel.
  always_comb begin
    press_nxt   = rise & mask_in;
    release_nxt = fall & mask_in;
    move_nxt    = '0;
    rep_last    = REPEAT_LAST;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      timer_nxt[i] = timer[i];
`ifdef BTN_TYPEMATIC_ACCEL_EN
      rep_cnt_nxt[i] = rep_cnt[i];
      rep_last = (rep_cnt[i] == ACCEL_LIM) ? FAST_LAST : REPEAT_LAST;
`else
      rep_last = REPEAT_LAST;
`endif
      // Masked channels and releases always return to IDLE with no move.
      if (!mask_in[i] || fall[i]) begin
        state_nxt[i] = ST_IDLE;
        timer_nxt[i] = '0;
`ifdef BTN_TYPEMATIC_ACCEL_EN
        rep_cnt_nxt[i] = '0;
`endif
      end else begin
        case (state[i])
          ST_IDLE: begin
`ifdef BTN_TYPEMATIC_ACCEL_EN
            rep_cnt_nxt[i] = '0;
`endif
            if (rise[i]) begin
              move_nxt[i]  = 1'b1;
              timer_nxt[i] = '0;
              state_nxt[i] = ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (timer[i] == DELAY_LAST) begin
              move_nxt[i]  = 1'b1;
              timer_nxt[i] = '0;
              state_nxt[i] = ST_REPEAT;
`ifdef BTN_TYPEMATIC_ACCEL_EN
              if (rep_cnt[i] != ACCEL_LIM) rep_cnt_nxt[i] = rep_cnt[i] + AW'(1);
`endif
            end else begin
              timer_nxt[i] = timer[i] + TW'(1);
            end
          end
          ST_REPEAT: begin
            if (timer[i] == rep_last) begin
              move_nxt[i]  = 1'b1;
              timer_nxt[i] = '0;
`ifdef BTN_TYPEMATIC_ACCEL_EN
              if (rep_cnt[i] != ACCEL_LIM) rep_cnt_nxt[i] = rep_cnt[i] + AW'(1);
`endif
            end else begin
              timer_nxt[i] = timer[i] + TW'(1);
            end
          end
          default: begin
            state_nxt[i] = ST_IDLE;
            timer_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  // FSM state, timers and registered event outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      press_out   <= '0;
      release_out <= '0;
      move_out    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i] <= ST_IDLE;
        timer[i] <= '0;
`ifdef BTN_TYPEMATIC_ACCEL_EN
        rep_cnt[i] <= '0;
`endif
      end
    end else begin
      press_out   <= press_nxt;
      release_out <= release_nxt;
      move_out    <= move_nxt;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i] <= state_nxt[i];
        timer[i] <= timer_nxt[i];
`ifdef BTN_TYPEMATIC_ACCEL_EN
        rep_cnt[i] <= rep_cnt_nxt[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_btn_typematic.sv
// tb_btn_typematic: directed self-checking bench for btn_typematic.
// Debounce acceptance latency from an input change driven at a falling edge
// is 7 rising edges (2 sync + candidate load + 3 count + level update).
module tb_btn_typematic;

  localparam int unsigned NCH = 5;
  localparam int          LAT = 7;

  logic           clk_in = 1'b0;
  logic           rst_n_in;
  logic [NCH-1:0] btn_in;
  logic [NCH-1:0] mask_in;
  logic [NCH-1:0] held_out;
  logic [NCH-1:0] press_out;
  logic [NCH-1:0] release_out;
  logic [NCH-1:0] move_out;

  int tests;
  int fails;

  btn_typematic #(
    .NUM_CH             (NCH),
    .LOG_DEBOUNCE_COUNT (2),
    .LOG_DELAY_COUNT    (4),
    .LOG_REPEAT_COUNT   (2),
    .ACCEL_AFTER        (2)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .btn_in      (btn_in),
    .mask_in     (mask_in),
    .held_out    (held_out),
    .press_out   (press_out),
    .release_out (release_out),
    .move_out    (move_out)
  );

  always #5 clk_in = ~clk_in;

  // Event log: cycle stamp of every pulse, per channel.
  int cyc;
  int press_t [NCH][32];
  int press_n [NCH];
  int rel_t   [NCH][32];
  int rel_n   [NCH];
  int move_t  [NCH][128];
  int move_n  [NCH];

  always @(posedge clk_in) begin
    #1;
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (press_out[i] === 1'b1 && press_n[i] < 32) begin
        press_t[i][press_n[i]] = cyc;
        press_n[i]++;
      end
      if (release_out[i] === 1'b1 && rel_n[i] < 32) begin
        rel_t[i][rel_n[i]] = cyc;
        rel_n[i]++;
      end
      if (move_out[i] === 1'b1 && move_n[i] < 128) begin
        move_t[i][move_n[i]] = cyc;
        move_n[i]++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic test_reset;
    int n;
    rst_n_in = 1'b0;
    btn_in   = 5'h1f;
    mask_in  = 5'h1f;
    cycles(3);
    tests++; if (held_out !== 5'h00) begin fails++; $display("FAIL reset_held: got %b expected %b", held_out, 5'h00); end
    tests++; if (press_out !== 5'h00) begin fails++; $display("FAIL reset_press: got %b expected %b", press_out, 5'h00); end
    tests++; if (release_out !== 5'h00) begin fails++; $display("FAIL reset_release: got %b expected %b", release_out, 5'h00); end
    tests++; if (move_out !== 5'h00) begin fails++; $display("FAIL reset_move: got %b expected %b", move_out, 5'h00); end
    rst_n_in = 1'b1;
    n = cyc;
    cycles(LAT - 1);
    tests++; if (held_out !== 5'h00) begin fails++; $display("FAIL reset_held_early: got %b expected %b at cyc %0d", held_out, 5'h00, cyc - n); end
    cycles(1);
    tests++; if (held_out !== 5'h1f) begin fails++; $display("FAIL reset_held_accept: got %b expected %b", held_out, 5'h1f); end
    tests++; if (press_out !== 5'h1f) begin fails++; $display("FAIL reset_press_accept: got %b expected %b", press_out, 5'h1f); end
    tests++; if (move_out !== 5'h1f) begin fails++; $display("FAIL reset_move_accept: got %b expected %b", move_out, 5'h1f); end
    btn_in = 5'h00;
    cycles(1);
    tests++; if (press_out !== 5'h00) begin fails++; $display("FAIL reset_press_pulse_width: got %b expected %b", press_out, 5'h00); end
    tests++; if (move_out !== 5'h00) begin fails++; $display("FAIL reset_move_pulse_width: got %b expected %b", move_out, 5'h00); end
    cycles(LAT - 2);
    tests++; if (held_out !== 5'h1f) begin fails++; $display("FAIL reset_held_before_release: got %b expected %b", held_out, 5'h1f); end
    cycles(1);
    tests++; if (held_out !== 5'h00) begin fails++; $display("FAIL reset_held_release: got %b expected %b", held_out, 5'h00); end
    tests++; if (release_out !== 5'h1f) begin fails++; $display("FAIL reset_release_pulse: got %b expected %b", release_out, 5'h1f); end
    cycles(10);
  endtask

  task automatic test_tap;
    int n, p, m, r;
    n = cyc; p = press_n[0]; m = move_n[0]; r = rel_n[0];
    btn_in[0] = 1'b1;
    cycles(12);
    btn_in[0] = 1'b0;
    cycles(20);
    tests++; if (press_n[0] - p !== 1) begin fails++; $display("FAIL tap_press_count: got %0d expected 1", press_n[0] - p); end
    tests++; if (press_t[0][p] !== n + LAT) begin fails++; $display("FAIL tap_press_time: got %0d expected %0d", press_t[0][p], n + LAT); end
    tests++; if (move_n[0] - m !== 1) begin fails++; $display("FAIL tap_move_count: got %0d expected 1", move_n[0] - m); end
    tests++; if (move_t[0][m] !== n + LAT) begin fails++; $display("FAIL tap_move_time: got %0d expected %0d", move_t[0][m], n + LAT); end
    tests++; if (rel_n[0] - r !== 1) begin fails++; $display("FAIL tap_release_count: got %0d expected 1", rel_n[0] - r); end
    tests++; if (rel_t[0][r] !== n + 12 + LAT) begin fails++; $display("FAIL tap_release_time: got %0d expected %0d", rel_t[0][r], n + 12 + LAT); end
  endtask

  task automatic test_hold;
`ifdef BTN_TYPEMATIC_ACCEL_EN
    int exp_off [12] = '{0, 16, 20, 22, 24, 26, 28, 30, 32, 34, 36, 38};
`else
    int exp_off [7] = '{0, 16, 20, 24, 28, 32, 36};
`endif
    int n, t, p, m, r;
    n = cyc; t = n + LAT; p = press_n[2]; m = move_n[2]; r = rel_n[2];
    btn_in[2] = 1'b1;
    cycles(40);
    btn_in[2] = 1'b0;
    cycles(20);
    tests++; if (press_n[2] - p !== 1) begin fails++; $display("FAIL hold_press_count: got %0d expected 1", press_n[2] - p); end
    tests++; if (move_n[2] - m !== $size(exp_off)) begin fails++; $display("FAIL hold_move_count: got %0d expected %0d", move_n[2] - m, $size(exp_off)); end
    for (int k = 0; k < $size(exp_off); k++) begin
      tests++;
      if (move_t[2][m + k] !== t + exp_off[k]) begin
        fails++;
        $display("FAIL hold_move_time[%0d]: got T+%0d expected T+%0d", k, move_t[2][m + k] - t, exp_off[k]);
      end
    end
    tests++; if (rel_t[2][r] !== t + 40) begin fails++; $display("FAIL hold_release_time: got T+%0d expected T+40", rel_t[2][r] - t); end
  endtask

  task automatic test_bounce;
    int p, m, r, seen;
    p = press_n[1]; m = move_n[1]; r = rel_n[1]; seen = 0;
    for (int k = 0; k < 30; k++) begin
      btn_in[1] = ((k / 2) % 2) == 0;
      cycles(1);
      if (held_out[1] !== 1'b0) seen++;
    end
    btn_in[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      if (held_out[1] !== 1'b0) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL bounce_held: held high for %0d cycles expected 0", seen); end
    tests++; if (press_n[1] - p !== 0) begin fails++; $display("FAIL bounce_press: got %0d expected 0", press_n[1] - p); end
    tests++; if (move_n[1] - m !== 0) begin fails++; $display("FAIL bounce_move: got %0d expected 0", move_n[1] - m); end
    tests++; if (rel_n[1] - r !== 0) begin fails++; $display("FAIL bounce_release: got %0d expected 0", rel_n[1] - r); end
  endtask

  task automatic test_mask;
    int p, m;
    mask_in[3] = 1'b0;
    btn_in[3]  = 1'b1;
    cycles(LAT);
    tests++; if (held_out[3] !== 1'b1) begin fails++; $display("FAIL mask_held_tracks: got %b expected 1", held_out[3]); end
    tests++; if (press_out[3] !== 1'b0) begin fails++; $display("FAIL mask_press_blocked: got %b expected 0", press_out[3]); end
    tests++; if (move_out[3] !== 1'b0) begin fails++; $display("FAIL mask_move_blocked: got %b expected 0", move_out[3]); end
    cycles(5);
    mask_in[3] = 1'b1;
    p = press_n[3]; m = move_n[3];
    cycles(30);
    tests++; if (press_n[3] - p !== 0) begin fails++; $display("FAIL mask_unmask_press: got %0d expected 0", press_n[3] - p); end
    tests++; if (move_n[3] - m !== 0) begin fails++; $display("FAIL mask_unmask_move: got %0d expected 0", move_n[3] - m); end
    tests++; if (held_out[3] !== 1'b1) begin fails++; $display("FAIL mask_held_after_unmask: got %b expected 1", held_out[3]); end
    btn_in[3] = 1'b0;
    cycles(LAT);
    tests++; if (release_out[3] !== 1'b1) begin fails++; $display("FAIL mask_release: got %b expected 1", release_out[3]); end
    cycles(5);
    btn_in[3] = 1'b1;
    cycles(LAT);
    tests++; if (press_out[3] !== 1'b1) begin fails++; $display("FAIL mask_repress_press: got %b expected 1", press_out[3]); end
    tests++; if (move_out[3] !== 1'b1) begin fails++; $display("FAIL mask_repress_move: got %b expected 1", move_out[3]); end
    btn_in[3] = 1'b0;
    cycles(15);
  endtask

  task automatic test_back_to_back;
`ifdef BTN_TYPEMATIC_ACCEL_EN
    int exp0 [7] = '{0, 16, 20, 22, 24, 26, 28};
`else
    int exp0 [5] = '{0, 16, 20, 24, 28};
`endif
    int n, t, p0, m0, r0, p4, m4, r4;
    n = cyc; t = n + LAT;
    p0 = press_n[0]; m0 = move_n[0]; r0 = rel_n[0];
    p4 = press_n[4]; m4 = move_n[4]; r4 = rel_n[4];
    btn_in[0] = 1'b1;
    btn_in[4] = 1'b1;
    cycles(17);
    btn_in[4] = 1'b0;
    cycles(13);
    btn_in[0] = 1'b0;
    cycles(20);
    tests++; if (press_t[0][p0] !== t) begin fails++; $display("FAIL b2b_ch0_press: got T+%0d expected T+0", press_t[0][p0] - t); end
    tests++; if (press_t[4][p4] !== t) begin fails++; $display("FAIL b2b_ch4_press: got T+%0d expected T+0", press_t[4][p4] - t); end
    tests++; if (move_n[4] - m4 !== 2) begin fails++; $display("FAIL b2b_ch4_move_count: got %0d expected 2", move_n[4] - m4); end
    tests++; if (move_t[4][m4 + 1] !== t + 16) begin fails++; $display("FAIL b2b_ch4_move1: got T+%0d expected T+16", move_t[4][m4 + 1] - t); end
    tests++; if (rel_t[4][r4] !== t + 17) begin fails++; $display("FAIL b2b_ch4_release: got T+%0d expected T+17", rel_t[4][r4] - t); end
    tests++; if (move_n[0] - m0 !== $size(exp0)) begin fails++; $display("FAIL b2b_ch0_move_count: got %0d expected %0d", move_n[0] - m0, $size(exp0)); end
    for (int k = 0; k < $size(exp0); k++) begin
      tests++;
      if (move_t[0][m0 + k] !== t + exp0[k]) begin
        fails++;
        $display("FAIL b2b_ch0_move[%0d]: got T+%0d expected T+%0d", k, move_t[0][m0 + k] - t, exp0[k]);
      end
    end
    tests++; if (rel_t[0][r0] !== t + 30) begin fails++; $display("FAIL b2b_ch0_release: got T+%0d expected T+30", rel_t[0][r0] - t); end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n_in = 1'b0;
    btn_in   = '0;
    mask_in  = '1;
    @(negedge clk_in);
    test_reset();
    test_tap();
    test_hold();
    test_bounce();
    test_mask();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
